// File: rtl/hack_core_p.sv
// hack_core_p: multi-cycle Hack CPU core with a stallable slow memory region and halt support
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   instruction            ROM word at prog_counter
//   mem_busy               slow region currently owned by another master
//   mem_rdata              read data for mem_address
//   halt                   request to stop at the next instruction boundary
//   mem_load               write strobe (mem_wdata -> mem_address), committing EXEC only
//   mem_address            A register
//   mem_wdata              combinational ALU result
//   prog_counter           ROM address
//   retire                 one-cycle pulse per completed instruction
//   halted                 high while in HALT
module hack_core_p #(
    parameter int WIDTH = 16,
    parameter logic [WIDTH-1:0] SLOW_MASK = WIDTH'(16'hE000),
    parameter logic [WIDTH-1:0] SLOW_BASE = WIDTH'(16'h4000),
    parameter int READ_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] instruction,
    input  logic             mem_busy,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             halt,
    output logic             mem_load,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [WIDTH-1:0] prog_counter,
    output logic             retire,
    output logic             halted
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MREAD  = 3'd3;
    localparam logic [2:0] S_MFETCH = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam int CW = $clog2(READ_LAT + 1);

    logic [2:0]       state;
    logic [WIDTH-1:0] a_reg, d_reg, m_reg, pc, x_reg, y_reg;
    // ctrl[11:6] ALU controls, ctrl[5:3] destinations (A, D, M), ctrl[2:0] jump
    logic [11:0]      ctrl;
    logic [CW-1:0]    wait_cnt;

    logic [WIDTH-1:0] xz, xn, yz, yn, fo, alu_out, pc_inc;
    logic             zero, neg, jump, slow, commit, a_instr;
    logic             unused_bits;

    assign unused_bits = ^instruction[WIDTH-2:13];

    assign xz      = ctrl[11] ? '0 : x_reg;
    assign xn      = ctrl[10] ? ~xz : xz;
    assign yz      = ctrl[9] ? '0 : y_reg;
    assign yn      = ctrl[8] ? ~yz : yz;
    assign fo      = ctrl[7] ? xn + yn : xn & yn;
    assign alu_out = ctrl[6] ? ~fo : fo;
    assign zero    = alu_out == '0;
    assign neg     = alu_out[WIDTH-1];
    assign jump    = (ctrl[2] & neg) | (ctrl[1] & zero) | (ctrl[0] & ~neg & ~zero);
    assign pc_inc  = pc + WIDTH'(1);

    // slow-region test always uses the current A, so a d1+d3 commit writes to the old A
    assign slow    = (a_reg & SLOW_MASK) == SLOW_BASE;
    assign commit  = state == S_EXEC && (!ctrl[3] || !slow || !mem_busy);
    assign a_instr = state == S_DECODE && !instruction[WIDTH-1];

    assign mem_load     = commit && ctrl[3];
    assign retire       = commit || a_instr;
    assign halted       = state == S_HALT;
    assign mem_address  = a_reg;
    assign mem_wdata    = alu_out;
    assign prog_counter = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            a_reg    <= '0;
            d_reg    <= '0;
            m_reg    <= '0;
            pc       <= '0;
            x_reg    <= '0;
            y_reg    <= '0;
            ctrl     <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_FETCH: state <= halt ? S_HALT : S_DECODE;
                S_DECODE: begin
                    if (!instruction[WIDTH-1]) begin
                        a_reg <= instruction;
                        pc    <= pc_inc;
                        state <= S_MREAD;
                    end else begin
                        x_reg <= d_reg;
                        y_reg <= instruction[12] ? m_reg : a_reg;
                        ctrl  <= instruction[11:0];
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (commit) begin
                        if (ctrl[5]) a_reg <= alu_out;
                        if (ctrl[4]) d_reg <= alu_out;
                        if (ctrl[3]) m_reg <= alu_out;
                        pc    <= jump ? a_reg : pc_inc;
                        state <= ctrl[5] ? S_MREAD : (halt ? S_HALT : S_FETCH);
                    end
                end
                S_MREAD: begin
                    // counter waits at 0 for the bus, then runs freely to READ_LAT
                    if (!slow || wait_cnt == CW'(READ_LAT))
                        state <= S_MFETCH;
                    else if (wait_cnt != '0 || !mem_busy)
                        wait_cnt <= wait_cnt + CW'(1);
                end
                S_MFETCH: begin
                    m_reg    <= mem_rdata;
                    wait_cnt <= '0;
                    state    <= halt ? S_HALT : S_DECODE;
                end
                S_HALT: if (!halt) state <= S_DECODE;
                default: state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_hack_core_p.sv
// tb_hack_core_p: vector table, directed multi-cycle sequences and a random ISA-level model check for hack_core_p
module tb_hack_core_p;
    localparam logic [15:0] NOP = 16'hEA80;

    logic clk = 1'b0;
    logic reset, mem_busy, halt, mem_load, retire, halted;
    logic [15:0] instruction, mem_rdata, mem_address, mem_wdata, prog_counter, rdata_drv;
    logic [15:0] rom [256];
    logic [15:0] dmem [65536];
    logic [15:0] mmem [65536];
    logic use_mem, model_on;
    logic [15:0] m_a, m_d, m_pc, waddr, wdata;
    int total = 0, bad = 0, nret, nwr, n0;

    typedef struct {
        logic [15:0] p0, p1, p2, p3;
        logic        busy;
        int          nret;
        logic [15:0] pc;
        int          nwr;
        logic [15:0] waddr, wdata;
    } vec_t;
    vec_t vt [12];

    always #5 clk = ~clk;

    assign instruction = rom[prog_counter[7:0]];
    assign mem_rdata   = use_mem ? dmem[mem_address] : rdata_drv;

    hack_core_p dut (
        .clk(clk), .reset(reset), .instruction(instruction), .mem_busy(mem_busy),
        .mem_rdata(mem_rdata), .halt(halt), .mem_load(mem_load), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .prog_counter(prog_counter), .retire(retire), .halted(halted)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic init_mem();
        for (int i = 0; i < 65536; i++) begin
            dmem[i] = 16'(i) ^ 16'hA5A5;
            mmem[i] = dmem[i];
        end
        for (int i = 0; i < 256; i++) rom[i] = NOP;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        halt  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        nret = 0; nwr = 0; waddr = '0; wdata = '0;
    endtask

    // instruction-level reference: one call per retired instruction
    task automatic model_check();
        logic [15:0] ins, x, y, o, old;
        logic j;
        ins = rom[m_pc[7:0]];
        chk("pc", 32'(prog_counter), 32'(m_pc));
        chk("a", 32'(mem_address), 32'(m_a));
        if (!ins[15]) begin
            chk("a_load", 32'(mem_load), 0);
            m_a  = ins;
            m_pc = m_pc + 16'd1;
        end else begin
            x = ins[11] ? 16'h0 : m_d;
            if (ins[10]) x = ~x;
            y = ins[12] ? mmem[m_a] : m_a;
            if (ins[9]) y = 16'h0;
            if (ins[8]) y = ~y;
            o = ins[7] ? x + y : x & y;
            if (ins[6]) o = ~o;
            j = (ins[2] && $signed(o) < 0) || (ins[1] && o == 16'h0) || (ins[0] && $signed(o) > 0);
            chk("c_load", 32'(mem_load), 32'(ins[3]));
            if (ins[3]) begin
                chk("c_wdata", 32'(mem_wdata), 32'(o));
                mmem[m_a] = o;
            end
            old = m_a;
            if (ins[5]) m_a = o;
            if (ins[4]) m_d = o;
            m_pc = j ? old : m_pc + 16'd1;
        end
    endtask

    // observe with this cycle's inputs, let the edge happen, then apply any memory write
    task automatic cyc();
        logic pw;
        logic [15:0] pa, pd;
        #1;
        pw = mem_load; pa = mem_address; pd = mem_wdata;
        if (retire) nret++;
        if (mem_load) begin
            nwr++; waddr = pa; wdata = pd;
            chk("load_retire", 32'(retire), 1);
        end
        if (model_on && retire) model_check();
        @(posedge clk);
        if (pw) dmem[pa] = pd;
        @(negedge clk);
    endtask

    task automatic run_ret(input int n, input int cap);
        for (int i = 0; i < cap && nret < n; i++) cyc();
        chk("progress", 32'(nret >= n), 1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{16'h0005, 16'hEC10, NOP, NOP, 1'b0, 2, 16'h0002, 0, 16'h0000, 16'h0000};
        vt[1]  = '{16'h0005, 16'hEC10, 16'hE308, NOP, 1'b0, 3, 16'h0003, 1, 16'h0005, 16'h0005};
        vt[2]  = '{16'hEE90, 16'h0020, 16'hE304, NOP, 1'b0, 3, 16'h0020, 0, 16'h0000, 16'h0000};
        vt[3]  = '{16'hEA90, 16'h0020, 16'hE304, NOP, 1'b0, 3, 16'h0003, 0, 16'h0000, 16'h0000};
        vt[4]  = '{16'h0007, 16'hEC10, 16'h6000, 16'hE308, 1'b1, 4, 16'h0004, 1, 16'h6000, 16'h0007};
        vt[5]  = '{16'hEEA0, 16'hEA87, NOP, NOP, 1'b0, 2, 16'hFFFF, 0, 16'h0000, 16'h0000};
        vt[6]  = '{16'hEEA0, 16'hEA87, NOP, NOP, 1'b0, 3, 16'h0000, 0, 16'h0000, 16'h0000};
        vt[7]  = '{16'h0010, 16'hEFE8, 16'hFC10, 16'hE308, 1'b0, 4, 16'h0004, 2, 16'h0001, 16'hA5A4};
        vt[8]  = '{16'h0005, 16'hEC10, 16'h0030, 16'hE301, 1'b0, 4, 16'h0030, 0, 16'h0000, 16'h0000};
        vt[9]  = '{16'hEA90, 16'h0040, 16'hE302, NOP, 1'b0, 3, 16'h0040, 0, 16'h0000, 16'h0000};
        vt[10] = '{16'h0005, 16'hEC10, 16'h0006, 16'hE008, 1'b0, 4, 16'h0004, 1, 16'h0006, 16'h0004};
        vt[11] = '{16'h0005, 16'hEC10, 16'h0007, 16'hE4C8, 1'b0, 4, 16'h0004, 1, 16'h0007, 16'hFFFE};
        model_on = 1'b0; use_mem = 1'b1; mem_busy = 1'b0; rdata_drv = '0;

        init_mem();
        do_reset();
        #1;
        chk("rst_load", 32'(mem_load), 0);
        chk("rst_retire", 32'(retire), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_addr", 32'(mem_address), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_pc", 32'(prog_counter), 0);
        @(negedge clk);

        for (int v = 0; v < 12; v++) begin
            init_mem();
            rom[0] = vt[v].p0; rom[1] = vt[v].p1; rom[2] = vt[v].p2; rom[3] = vt[v].p3;
            mem_busy = vt[v].busy;
            do_reset();
            run_ret(vt[v].nret, 200);
            chk($sformatf("v%0d_pc", v), 32'(prog_counter), 32'(vt[v].pc));
            chk($sformatf("v%0d_nwr", v), 32'(nwr), 32'(vt[v].nwr));
            chk($sformatf("v%0d_waddr", v), 32'(waddr), 32'(vt[v].waddr));
            chk($sformatf("v%0d_wdata", v), 32'(wdata), 32'(vt[v].wdata));
        end

        // slow read: M must capture the rdata presented on the 4th edge counting the first busy-low sample
        init_mem();
        rom[0] = 16'h4000; rom[1] = 16'hFC10; rom[2] = 16'hE308;
        use_mem = 1'b0; mem_busy = 1'b1;
        do_reset();
        run_ret(1, 20);
        repeat (3) cyc();
        chk("slow_wait_ret", 32'(nret), 1);
        mem_busy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rdata_drv = 16'h1230 + 16'(k);
            cyc();
        end
        run_ret(3, 20);
        chk("slow_nwr", 32'(nwr), 1);
        chk("slow_waddr", 32'(waddr), 32'h4000);
        chk("slow_capture", 32'(wdata), 32'h1233);
        use_mem = 1'b1;

        // slow write stall with halt raised mid-stall
        init_mem();
        rom[0] = 16'h0007; rom[1] = 16'hEC10; rom[2] = 16'h4000; rom[3] = 16'hE308;
        mem_busy = 1'b0;
        do_reset();
        run_ret(3, 50);
        repeat (4) cyc();
        mem_busy = 1'b1; halt = 1'b1;
        cyc();
        repeat (4) begin
            #1;
            chk("stall_load", 32'(mem_load), 0);
            chk("stall_retire", 32'(retire), 0);
            chk("stall_pc", 32'(prog_counter), 3);
            cyc();
        end
        mem_busy = 1'b0;
        #1;
        chk("commit_load", 32'(mem_load), 1);
        chk("commit_wdata", 32'(mem_wdata), 7);
        chk("commit_addr", 32'(mem_address), 32'h4000);
        chk("commit_retire", 32'(retire), 1);
        cyc();
        repeat (3) begin
            #1;
            chk("halt_flag", 32'(halted), 1);
            chk("halt_pc", 32'(prog_counter), 4);
            chk("halt_retire", 32'(retire), 0);
            cyc();
        end
        halt = 1'b0;
        cyc();
        #1;
        chk("resume_halted", 32'(halted), 0);
        n0 = nret;
        run_ret(n0 + 1, 20);
        chk("resume_pc", 32'(prog_counter), 5);

        // reset in the middle of a slow read
        init_mem();
        rom[0] = 16'hEE90; rom[1] = 16'h4000;
        mem_busy = 1'b0;
        do_reset();
        run_ret(2, 50);
        cyc();
        mem_busy = 1'b1;
        cyc();
        #1;
        chk("pre_rst_wdata", 32'(mem_wdata), 32'hFFFF);
        chk("pre_rst_addr", 32'(mem_address), 32'h4000);
        reset = 1'b1;
        cyc();
        #1;
        chk("mid_rst_load", 32'(mem_load), 0);
        chk("mid_rst_retire", 32'(retire), 0);
        chk("mid_rst_halted", 32'(halted), 0);
        chk("mid_rst_addr", 32'(mem_address), 0);
        chk("mid_rst_wdata", 32'(mem_wdata), 0);
        chk("mid_rst_pc", 32'(prog_counter), 0);
        reset = 1'b0; mem_busy = 1'b0;
        nret = 0;
        run_ret(1, 20);
        chk("post_rst_pc", 32'(prog_counter), 1);

        // random programs against the instruction-level model
        init_mem();
        dmem[0] = '0; mmem[0] = '0;
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 3))
                    0: rom[i] = 16'($urandom_range(0, 31));
                    1: rom[i] = 16'h4000 + 16'($urandom_range(0, 31));
                    2: rom[i] = 16'h6000 + 16'($urandom_range(0, 31));
                    default: rom[i] = 16'($urandom_range(0, 16'h7FFF));
                endcase
            end else begin
                rom[i] = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
            end
        end
        mem_busy = 1'b0;
        do_reset();
        m_a = '0; m_d = '0; m_pc = '0;
        model_on = 1'b1;
        for (int i = 0; i < 20000 && nret < 400; i++) begin
            mem_busy = $urandom_range(0, 3) == 0;
            halt     = $urandom_range(0, 15) == 0;
            cyc();
        end
        model_on = 1'b0; halt = 1'b0;
        chk("rand_progress", 32'(nret >= 400), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
